serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, as the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL provide port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst, input, 1 bit, synchronous active-high reset sampled on the clk rising edge.
REQ-004 The block SHALL provide port start, input, 1 bit, a request to begin a subtraction; it is honoured only in IDLE.
REQ-005 The block SHALL provide port a, input, WIDTH bits, the unsigned minuend, sampled only on the accepting edge.
REQ-006 The block SHALL provide port b, input, WIDTH bits, the unsigned subtrahend, sampled only on the accepting edge.
REQ-007 The block SHALL provide port busy, output, 1 bit, high while an operation is in progress (state SHIFT).
REQ-008 The block SHALL provide port done, output, 1 bit, a one-cycle pulse marking a new valid result.
REQ-009 The block SHALL provide port diff, output, WIDTH bits, the registered result a-b modulo 2^WIDTH.
REQ-010 The block SHALL provide port borrow_out, output, 1 bit, the registered final borrow (1 iff a<b unsigned).

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 on an edge, the block SHALL load a and b into internal shift registers, clear the running borrow, clear the bit counter and enter SHIFT.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-014 In SHIFT, the block SHALL process exactly one bit per cycle, LSB first, using one full-subtractor cell: d = ai^bi^br; br_next = (~ai&bi) | (~(ai^bi)&br).
REQ-015 Each SHIFT cycle SHALL shift d into the MSB of an internal result register, shift both operand registers right by one and increment the counter.
REQ-016 After the WIDTH-th SHIFT edge, the block SHALL enter DONE, copying the result register to diff and the final borrow to borrow_out on that same edge.
REQ-017 In DONE, the block SHALL assert done=1 for exactly one cycle and return to IDLE on the next edge unconditionally.
REQ-018 Latency SHALL be fixed: if start is accepted on edge k, done SHALL be high in the cycle after edge k+WIDTH, and low again after edge k+WIDTH+1.
REQ-019 busy SHALL be 1 exactly in SHIFT (from edge k through edge k+WIDTH) and 0 in IDLE and DONE.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored, with no queuing; the in-flight operation SHALL be unaffected.
REQ-021 Changes on a or b after the accepting edge SHALL NOT affect the result.
REQ-022 diff and borrow_out SHALL hold their values from one DONE entry until the next DONE entry, including through IDLE and SHIFT.
REQ-023 A start held high continuously SHALL produce back-to-back operations, one every WIDTH+2 cycles (accepted in IDLE after each DONE).
REQ-024 Equal operands SHALL give diff=0 and borrow_out=0; a=0, b=2^WIDTH-1 SHALL give diff=1 and borrow_out=1.

Reset
REQ-025 rst=1 on an edge SHALL force state IDLE, busy=0, done=0, diff=0, borrow_out=0, and clear the counter, borrow and shift registers.
REQ-026 rst SHALL take priority over start and over any state, including mid-SHIFT; an aborted operation SHALL never produce done.
REQ-027 On the first edge with rst=0 and start=1, the block SHALL accept the operation normally.

Verification (WIDTH=8)
REQ-028 Bench: a=0x5A, b=0x23, start pulse -> done exactly 9 edges after acceptance; diff=0x37, borrow_out=0; busy high for 8 cycles.
REQ-029 Bench: a=0x10, b=0x20 -> diff=0xF0, borrow_out=1; then a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-030 Bench: a=0xA5, b=0xA5 -> diff=0x00, borrow_out=0; then a=0xFF, b=0x00 -> diff=0xFF, borrow_out=0.
REQ-031 Bench: start a=0x5A, b=0x23, then pulse start with a=0x01, b=0x02 at SHIFT cycle 3, and change a/b mid-op -> single done, diff=0x37.
REQ-032 Bench: rst=1 at SHIFT cycle 4 -> next cycle busy=0, done=0, diff=0, borrow_out=0, and no done for 20 cycles.
REQ-033 Bench: start held high for 3 operations -> done pulses spaced 10 cycles apart; exhaustive random a/b checked against (a-b) mod 256 and (a<b).

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell processes a - b LSB first,
// one bit per clock, and delivers a registered WIDTH-bit difference plus final borrow.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             d_bit;
   logic             br_next;
   logic             last_bit;
   logic [WIDTH-1:0] res_next;

   // Full-subtractor cell on the current LSBs plus the running borrow.
   always_comb begin
      d_bit    = a_sr[0] ^ b_sr[0] ^ br;
      br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      res_next = {d_bit, res_sr[WIDTH-1:1]};
      last_bit = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         br         <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  br   <= 1'b0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               res_sr <= res_next;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               br     <= br_next;
               cnt    <= cnt + CW'(1);
               // The final bit is folded into the result as it is published.
               if (last_bit) begin
                  diff       <= res_next;
                  borrow_out <= br_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level reference model compared every
// cycle, plus directed operations with hand-computed results, latency and pulse checks.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: n = edges since acceptance, -1 when no operation is in flight.
   int           n           = -1;
   logic [W-1:0] m_a         = '0;
   logic [W-1:0] m_b         = '0;
   logic [W-1:0] exp_diff    = '0;
   logic         exp_borrow  = 1'b0;
   bit           model_valid = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      model_valid = 1'b1;
      if (rst) begin
         n          = -1;
         exp_diff   = '0;
         exp_borrow = 1'b0;
      end else if (n < 0) begin
         if (start) begin
            m_a = a;
            m_b = b;
            n   = 0;
         end
      end else begin
         n++;
         if (n == W) begin
            exp_diff   = m_a - m_b;
            exp_borrow = (m_a < m_b);
         end else if (n == W + 1) begin
            n = -1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("model_busy",   32'(busy),       32'(n >= 0 && n < W));
         check("model_done",   32'(done),       32'(n == W));
         check("model_diff",   32'(diff),       32'(exp_diff));
         check("model_borrow", 32'(borrow_out), 32'(exp_borrow));
      end
   end

   // One operation from IDLE: checks latency, busy length, result and single-cycle done.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input string nm);
      int lat;
      int bcnt;
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = ~av;
      b     = ~bv;
      lat   = 1;
      bcnt  = busy ? 1 : 0;
      while (!done && lat < 30) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
      end
      check({nm, "_latency"}, 32'(lat), 32'd9);
      check({nm, "_busy_cycles"}, 32'(bcnt), 32'd8);
      check({nm, "_diff"}, 32'(diff), 32'(ed));
      check({nm, "_borrow"}, 32'(borrow_out), 32'(eb));
      @(negedge clk);
      check({nm, "_done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      int dcount;
      int dtimes[3];
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_diff", 32'(diff), 32'd0);
      check("reset_borrow", 32'(borrow_out), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_op(8'h5A, 8'h23, 8'h37, 1'b0, "op_5a_23");
      run_op(8'h10, 8'h20, 8'hF0, 1'b1, "op_10_20");
      run_op(8'h00, 8'h01, 8'hFF, 1'b1, "op_00_01");
      run_op(8'hA5, 8'hA5, 8'h00, 1'b0, "op_equal");
      run_op(8'hFF, 8'h00, 8'hFF, 1'b0, "op_ff_00");
      run_op(8'h00, 8'hFF, 8'h01, 1'b1, "op_00_ff");
      run_op(8'h80, 8'h7F, 8'h01, 1'b0, "op_80_7f");

      // start and operand changes while shifting must be ignored
      @(negedge clk);
      a = 8'h5A; b = 8'h23; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; a = 8'h01; b = 8'h02;
      @(negedge clk);
      start = 1'b0; a = 8'hFF; b = 8'hFF;
      dcount = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) begin
            dcount++;
            check("midop_diff", 32'(diff), 32'h37);
            check("midop_borrow", 32'(borrow_out), 32'd0);
         end
      end
      check("midop_done_count", 32'(dcount), 32'd1);

      // reset during SHIFT aborts the operation
      run_op(8'h10, 8'h20, 8'hF0, 1'b1, "pre_abort");
      @(negedge clk);
      a = 8'h5A; b = 8'h23; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_borrow", 32'(borrow_out), 32'd0);
      dcount = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("abort_no_done", 32'(dcount), 32'd0);

      // start presented during reset is accepted on the first edge out of reset
      rst = 1'b1; start = 1'b1; a = 8'h80; b = 8'h7F;
      @(negedge clk);
      rst = 1'b0;
      check("rst_start_idle", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      check("rst_start_accepted", 32'(busy), 32'd1);
      dcount = 0;
      while (!done && dcount < 30) begin
         @(negedge clk);
         dcount++;
      end
      check("rst_start_latency", 32'(dcount), 32'd8);
      check("rst_start_diff", 32'(diff), 32'h01);
      @(negedge clk);

      // start held high: back-to-back operations every W+2 cycles
      @(negedge clk);
      a = 8'h5A; b = 8'h23; start = 1'b1;
      dcount = 0;
      for (int i = 0; i < 60 && dcount < 3; i++) begin
         @(negedge clk);
         if (done) begin
            dtimes[dcount] = cyc;
            dcount++;
            check("b2b_diff", 32'(diff), 32'h37);
         end
      end
      start = 1'b0;
      check("b2b_done_count", 32'(dcount), 32'd3);
      check("b2b_spacing_1", 32'(dtimes[1] - dtimes[0]), 32'd10);
      check("b2b_spacing_2", 32'(dtimes[2] - dtimes[1]), 32'd10);
      repeat (2) @(negedge clk);

      for (int i = 0; i < 200; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op(ra, rb, ra - rb, (ra < rb), "random");
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
